elastic_tap_delay: RTL and testbench

- Parametrised successor to the fixed delayN/ft_delay shift pipelines: a WID-bit, DEP-stage delay line.
- Adds per-stage valid tracking, a runtime-selectable output tap for programmable latency, synchronous flush and an occupancy counter.
- Used in NoC and datapath pipelines where the latency to match is known only at configuration time and bubbles must be tracked rather than assumed.

---
 rtl/elastic_tap_delay.sv | 58 +++++
 tb/tb_elastic_tap_delay.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/elastic_tap_delay.sv
// elastic_tap_delay: WID-bit, DEP-stage delay line with per-stage valid bits, runtime tap select, flush and occupancy count
module elastic_tap_delay #(
  parameter int WID = 8,
  parameter int DEP = 8,
  parameter int SELW = $clog2(DEP),
  parameter bit RESET_DATA = 1'b1,
  parameter bit ZERO_INVALID = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  input  logic            flush,
  input  logic [SELW-1:0] sel,
  input  logic            i_valid,
  input  logic [WID-1:0]  i,
  output logic            o_valid,
  output logic [WID-1:0]  o,
  output logic [SELW-1:0] sel_q,
  output logic [SELW:0]   cnt,
  output logic            empty
);
  localparam logic [SELW-1:0] MAX_SEL = SELW'(DEP - 1);
  logic [WID-1:0] d [DEP];
  logic [DEP-1:0] v;
  logic [SELW:0]  cnt_n;
  logic [SELW-1:0] sel_c;
  // occupancy after this edge; the tap may only move when it lands on zero
  always_comb begin
    cnt_n = (!rst_n || flush) ? '0
          : ce ? cnt + (SELW+1)'(i_valid) - (SELW+1)'(v[DEP-1])
          : cnt;
    sel_c = (sel > MAX_SEL) ? MAX_SEL : sel;
  end
  // valid chain, occupancy and tap commit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v     <= '0;
      sel_q <= '0;
    end else begin
      if (flush) v <= '0;
      else if (ce) v <= {v[DEP-2:0], i_valid};
      if (cnt_n == '0) sel_q <= sel_c;
    end
    cnt <= cnt_n;
  end
  // data chain shifts on every ce edge regardless of valid
  always_ff @(posedge clk) begin
    if (RESET_DATA && (!rst_n || flush)) begin
      for (int k = 0; k < DEP; k++) d[k] <= '0;
    end else if (rst_n && !flush && ce) begin
      d[0] <= i;
      for (int k = 1; k < DEP; k++) d[k] <= d[k-1];
    end
  end
  assign o_valid = v[sel_q];
  assign o       = (ZERO_INVALID && !o_valid) ? '0 : d[sel_q];
  assign empty   = (cnt == '0);
endmodule

// File: tb/tb_elastic_tap_delay.sv
// tb_elastic_tap_delay: table, directed and random checks against a latency-history model
module tb_elastic_tap_delay;
  localparam int DEP = 8;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0, ce = 1'b0, flush = 1'b0, i_valid = 1'b0;
  logic [2:0] sel = '0;
  logic [7:0] i = '0;
  logic       o_valid, empty;
  logic [7:0] o;
  logic [2:0] sel_q;
  logic [3:0] cnt;
  int checks = 0, failures = 0;
  bit started = 0;

  elastic_tap_delay #(.WID(8), .DEP(DEP)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .flush(flush), .sel(sel),
    .i_valid(i_valid), .i(i), .o_valid(o_valid), .o(o),
    .sel_q(sel_q), .cnt(cnt), .empty(empty)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (started) assert (cnt <= DEP) else $error("FAIL cnt_bound actual=%0d required<=%0d", cnt, DEP);

  // model: history of beats accepted on ce edges since the last reset/flush, newest last
  typedef struct packed { logic v; logic [7:0] d; } beat_t;
  beat_t hist[$];
  int selq_m = 0;

  function automatic int mcnt();
    int c = 0;
    foreach (hist[k]) c += int'(hist[k].v);
    return c;
  endfunction

  task automatic model(input logic r, input logic f, input logic c, input logic iv,
                       input logic [7:0] id, input logic [2:0] s);
    if (!r) begin
      hist.delete();
      selq_m = 0;
    end else begin
      if (f) hist.delete();
      else if (c) begin
        hist.push_back({iv, id});
        if (hist.size() > DEP) void'(hist.pop_front());
      end
      if (mcnt() == 0) selq_m = (int'(s) > DEP - 1) ? DEP - 1 : int'(s);
    end
  endtask

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic c, input logic iv,
                      input logic [7:0] id, input logic [2:0] s);
    int ev, eo;
    rst_n = r; flush = f; ce = c; i_valid = iv; i = id; sel = s;
    @(posedge clk);
    model(r, f, c, iv, id, s);
    #1;
    ev = (hist.size() > selq_m) ? int'(hist[hist.size() - 1 - selq_m].v) : 0;
    eo = ev ? int'(hist[hist.size() - 1 - selq_m].d) : 0;
    chk("o_valid", int'(o_valid), ev);
    chk("o", int'(o), eo);
    chk("sel_q", int'(sel_q), selq_m);
    chk("cnt", int'(cnt), mcnt());
    chk("empty", int'(empty), int'(mcnt() == 0));
  endtask

  task automatic idle(input int n, input logic [2:0] s);
    for (int k = 0; k < n; k++) step(1, 0, 1, 0, 8'h00, s);
  endtask

  typedef struct {
    logic ce, iv; logic [7:0] i; logic [2:0] sel;
    logic eov; logic [7:0] eo; logic [3:0] ecnt; logic [2:0] eselq;
  } vec_t;
  vec_t tbl[12];

  initial begin
    tbl = '{
      '{1'b1, 1'b0, 8'h00, 3'd3, 1'b0, 8'h00, 4'd0, 3'd3},
      '{1'b1, 1'b1, 8'h11, 3'd3, 1'b0, 8'h00, 4'd1, 3'd3},
      '{1'b1, 1'b1, 8'h22, 3'd3, 1'b0, 8'h00, 4'd2, 3'd3},
      '{1'b1, 1'b1, 8'h33, 3'd3, 1'b0, 8'h00, 4'd3, 3'd3},
      '{1'b1, 1'b0, 8'h00, 3'd3, 1'b1, 8'h11, 4'd3, 3'd3},
      '{1'b1, 1'b0, 8'h00, 3'd3, 1'b1, 8'h22, 4'd3, 3'd3},
      '{1'b1, 1'b0, 8'h00, 3'd3, 1'b1, 8'h33, 4'd3, 3'd3},
      '{1'b1, 1'b0, 8'h00, 3'd3, 1'b0, 8'h00, 4'd3, 3'd3},
      '{1'b1, 1'b0, 8'h00, 3'd3, 1'b0, 8'h00, 4'd3, 3'd3},
      '{1'b1, 1'b0, 8'h00, 3'd3, 1'b0, 8'h00, 4'd2, 3'd3},
      '{1'b1, 1'b0, 8'h00, 3'd3, 1'b0, 8'h00, 4'd1, 3'd3},
      '{1'b1, 1'b0, 8'h00, 3'd3, 1'b0, 8'h00, 4'd0, 3'd3}
    };
    step(0, 0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 0, 8'h00, 0);
    started = 1;
    chk("rst_empty", int'(empty), 1);
    chk("rst_o", int'(o), 0);

    // fixed latency, sel=3
    foreach (tbl[k]) begin
      step(1, 0, tbl[k].ce, tbl[k].iv, tbl[k].i, tbl[k].sel);
      chk("tbl_ov", int'(o_valid), int'(tbl[k].eov));
      chk("tbl_o", int'(o), int'(tbl[k].eo));
      chk("tbl_cnt", int'(cnt), int'(tbl[k].ecnt));
      chk("tbl_selq", int'(sel_q), int'(tbl[k].eselq));
    end

    // ce stall with sel=1
    idle(10, 1);
    step(1, 0, 1, 1, 8'hA5, 1);
    chk("stall_cnt0", int'(cnt), 1);
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 0, 0, 8'h00, 1);
      chk("stall_cnt", int'(cnt), 1);
      chk("stall_ov", int'(o_valid), 0);
    end
    step(1, 0, 1, 0, 8'h00, 1);
    chk("stall_out_ov", int'(o_valid), 1);
    chk("stall_out_o", int'(o), 8'hA5);

    // tap change while busy
    idle(10, 2);
    step(1, 0, 1, 1, 8'h31, 2);
    step(1, 0, 1, 1, 8'h32, 6);
    chk("tap_hold", int'(sel_q), 2);
    begin
      int n = 0;
      while (mcnt() != 0 && n < 20) begin
        step(1, 0, 1, 0, 8'h00, 6);
        n++;
      end
      chk("tap_drain_timeout", int'(n < 20), 1);
    end
    chk("tap_commit", int'(sel_q), 6);
    step(1, 0, 1, 1, 8'h40, 6);
    for (int k = 1; k <= 6; k++) begin
      step(1, 0, 1, 0, 8'h00, 6);
      chk("lat7_ov", int'(o_valid), int'(k == 6));
    end
    chk("lat7_o", int'(o), 8'h40);

    // deepest tap with a bubble
    idle(10, 7);
    chk("clamp_selq", int'(sel_q), 7);
    step(1, 0, 1, 1, 8'h5A, 7);
    step(1, 0, 1, 0, 8'h99, 7);
    step(1, 0, 1, 1, 8'hC3, 7);
    idle(4, 7);
    step(1, 0, 1, 0, 8'h00, 7);
    chk("bub1_ov", int'(o_valid), 1);
    chk("bub1_o", int'(o), 8'h5A);
    step(1, 0, 1, 0, 8'h00, 7);
    chk("bub0_ov", int'(o_valid), 0);
    chk("bub0_o", int'(o), 0);
    step(1, 0, 1, 0, 8'h00, 7);
    chk("bub2_ov", int'(o_valid), 1);
    chk("bub2_o", int'(o), 8'hC3);

    // flush collides with an incoming beat
    step(1, 0, 1, 1, 8'h71, 7);
    step(1, 0, 1, 1, 8'h72, 7);
    step(1, 0, 1, 1, 8'h73, 7);
    step(1, 1, 1, 1, 8'h77, 0);
    chk("flush_cnt", int'(cnt), 0);
    chk("flush_ov", int'(o_valid), 0);
    chk("flush_selq", int'(sel_q), 0);
    for (int k = 0; k < 10; k++) begin
      step(1, 0, 1, 0, 8'h00, 0);
      chk("flush_o", int'(o), 0);
    end

    // reset with a full chain and ce low
    for (int k = 0; k < DEP; k++) step(1, 0, 1, 1, 8'(8'hD0 + k), 0);
    chk("full_cnt", int'(cnt), 8);
    step(0, 0, 0, 0, 8'h00, 5);
    chk("mrst_cnt", int'(cnt), 0);
    chk("mrst_selq", int'(sel_q), 0);
    chk("mrst_ov", int'(o_valid), 0);
    chk("mrst_o", int'(o), 0);
    chk("mrst_empty", int'(empty), 1);
    step(1, 0, 1, 1, 8'hE1, 0);
    chk("refill_o", int'(o), 8'hE1);
    chk("refill_cnt", int'(cnt), 1);

    // randomized traffic
    for (int k = 0; k < 3000; k++)
      step(logic'($urandom_range(0, 199) != 0), logic'($urandom_range(0, 49) == 0),
           logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 2) == 0),
           8'($urandom), 3'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
